// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchronizer, glitch rejection and break handling.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity bit after data bit 7).
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       rx_dv,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_BREAK  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_dv_q, rx_dv_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
`endif
  logic            rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d   = S_START;
          clk_cnt_d = '0;
        end
      end
      S_START: begin
        // Re-check the line at mid start bit so short low glitches are dropped.
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          par_d     = rx_s;
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_q}) begin
              frame_err_d = 1'b1;
            end else begin
              rx_byte_d = shift_q;
              rx_dv_d   = 1'b1;
            end
`else
            rx_byte_d = shift_q;
            rx_dv_d   = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_byte_q   <= 8'h00;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign rx_dv     = rx_dv_q;
  assign rx_byte   = rx_byte_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at CLKS_PER_BIT=16; honours UART_RX_PARITY_EN.
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       frame_err;
  logic       busy;
  logic [2:0] dbg_state;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .frame_err(frame_err), .busy(busy), .dbg_state(dbg_state)
  );

  // Expected events: bit 8 set = frame error, clear = valid byte in bits 7:0.
  logic [8:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         frame_start_cyc = 0;
  int         last_dv_cyc = -1;
  logic [7:0] model_byte = 8'h00;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // driver: one frame; a low stop bit is followed by hold_low more low cycles then idle
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip,
                            input int hold_low);
    logic par;
    logic good;
    par  = (^b) ^ par_flip;
    good = stop_v;
`ifdef UART_RX_PARITY_EN
    if (par_flip) good = 1'b0;
`endif
    exp_q.push_back(good ? {1'b0, b} : {1'b1, 8'h00});
    frame_start_cyc = cyc;
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    wait_cyc(CPB);
`endif
    rx = stop_v;
    wait_cyc(CPB);
    if (!stop_v) begin
      wait_cyc(hold_low);
      rx = 1'b1;
      wait_cyc(4);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!reset_n) begin
      model_byte = 8'h00;
    end else begin
      checks++;
      if (rx_dv && frame_err) begin
        errors++;
        $display("FAIL dv_err_overlap: rx_dv=%b frame_err=%b required not both", rx_dv, frame_err);
      end
      if (rx_dv || frame_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: rx_dv=%b frame_err=%b byte=%0h with none expected",
                   rx_dv, frame_err, rx_byte);
        end else begin
          logic [8:0] e;
          logic [8:0] a;
          e = exp_q.pop_front();
          a = rx_dv ? {1'b0, rx_byte} : {1'b1, 8'h00};
          if (a !== e) begin
            errors++;
            $display("FAIL event: got %0h expected %0h (bit8=frame_err)", a, e);
          end
          if (!e[8]) model_byte = e[7:0];
          if (rx_dv) last_dv_cyc = cyc;
        end
      end
      checks++;
      if (rx_byte !== model_byte) begin
        errors++;
        $display("FAIL rx_byte_stable: got %0h expected %0h", rx_byte, model_byte);
      end
    end
  end

  initial begin
    int n;
    rx = 1'b1;
    reset_n = 1'b0;
    wait_cyc(3);
    check("reset_dv", {31'd0, rx_dv}, 0);
    check("reset_err", {31'd0, frame_err}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_byte", {24'd0, rx_byte}, 0);
    reset_n = 1'b1;
    wait_cyc(5);
    check("idle_busy", {31'd0, busy}, 0);

    // 1: single frame and latency
    send_frame(8'h51, 1'b1, 1'b0, 0);
    wait_cyc(4);
    n = last_dv_cyc - frame_start_cyc;
`ifdef UART_RX_PARITY_EN
    n = n - CPB;
`endif
    check("latency_ok", {31'd0, (n >= LAT - 1 && n <= LAT + 1)}, 1);
    check("byte_51", {24'd0, rx_byte}, 32'h51);

    // 2: back-to-back
    send_frame(8'h30, 1'b1, 1'b0, 0);
    send_frame(8'h37, 1'b1, 1'b0, 0);
    send_frame(8'h53, 1'b1, 1'b0, 0);
    wait_cyc(10);
    check("b2b_drained", exp_q.size(), 0);

    // 3: glitch
    rx = 1'b0;
    wait_cyc(5);
    rx = 1'b1;
    wait_cyc(CPB);
    check("glitch_busy", {31'd0, busy}, 0);
    send_frame(8'h44, 1'b1, 1'b0, 0);
    wait_cyc(4);

    // 4: bad stop, held low
    send_frame(8'h44, 1'b0, 1'b0, 36);
    // send_frame already released the line; re-run a held break to observe busy
    rx = 1'b0;
    exp_q.push_back({1'b1, 8'h00});
    frame_start_cyc = cyc;
    wait_cyc(10 * CPB + 20);
    check("break_busy", {31'd0, busy}, 1);
    rx = 1'b1;
    wait_cyc(8);
    check("break_exit_busy", {31'd0, busy}, 0);
    send_frame(8'h44, 1'b1, 1'b0, 0);
    wait_cyc(4);

    // 5: reset during data bit 4 of 0x53 (bit 4 is 1, bits 0..3 are 1,1,0,0)
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h53 >> i) & 8'h01;
      wait_cyc(CPB);
    end
    rx = 1'b1;
    wait_cyc(CPB / 2);
    check("midframe_busy", {31'd0, busy}, 1);
    reset_n = 1'b0;
    #2;
    check("rst_dv", {31'd0, rx_dv}, 0);
    check("rst_err", {31'd0, frame_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_byte", {24'd0, rx_byte}, 0);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(2 * CPB);
    check("post_rst_busy", {31'd0, busy}, 0);
    send_frame(8'h53, 1'b1, 1'b0, 0);
    wait_cyc(4);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then bad
    send_frame(8'h53, 1'b1, 1'b0, 0);
    send_frame(8'h53, 1'b1, 1'b1, 0);
    wait_cyc(4);
    check("parity_byte", {24'd0, rx_byte}, 32'h53);
`endif

    // random frames
    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      logic       sv;
      logic       pf;
      b  = 8'($urandom_range(0, 255));
      sv = ($urandom_range(0, 5) != 0);
      pf = ($urandom_range(0, 3) == 0);
      send_frame(b, sv, pf, $urandom_range(0, 30));
      wait_cyc($urandom_range(0, 3));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      wait_cyc(1);
      n++;
    end
    check("final_drained", exp_q.size(), 0);
    check("final_idle", {31'd0, busy}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
